usb2_ep1_fill: RTL and testbench

USB2_EP1_FILL -- requirements
Module: usb2_ep1_fill

---
 rtl/usb2_ep1_fill.sv | 94 +++++++++
 tb/tb_usb2_ep1_fill.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb2_ep1_fill.sv
// usb2_ep1_fill: packs an application byte stream into 512-byte endpoint IN packets.
// Define USB2_EP1_FILL_TIMEOUT_EN to flush a partial packet after TIMEOUT_CYCLES idle cycles.
module usb2_ep1_fill #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       phy_clk,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [8:0] buf_in_addr,
    output logic [7:0] buf_in_data,
    output logic       buf_in_wren,
    output logic       pkt_ready,
    output logic [9:0] pkt_len,
    input  logic       pkt_done
);
    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_HOLD} state_t;
    state_t     state;
    logic [9:0] cnt;
    logic       pend;
    logic       done_q;
    logic       acc;
    logic       done_rise;
    logic       to_hit;
    logic       commit;
    logic [9:0] cnt_next;
    assign acc       = in_valid & in_ready;
    assign done_rise = pkt_done & ~done_q;
    assign cnt_next  = acc ? cnt + 10'd1 : cnt;
    assign commit    = (acc && (cnt == 10'd511 || in_last)) || to_hit;
`ifdef USB2_EP1_FILL_TIMEOUT_EN
    logic [15:0] tcnt;
    assign to_hit = state == ST_FILL && !acc && tcnt == 16'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n)
            tcnt <= '0;
        else
            tcnt <= (state == ST_FILL && !acc && !to_hit) ? tcnt + 16'd1 : 16'd0;
    end
`else
    assign to_hit = 1'b0;
`endif
    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pend        <= 1'b0;
            done_q      <= 1'b0;
            in_ready    <= 1'b0;
            buf_in_addr <= '0;
            buf_in_data <= '0;
            buf_in_wren <= 1'b0;
            pkt_ready   <= 1'b0;
            pkt_len     <= '0;
        end else begin
            done_q      <= pkt_done;
            buf_in_wren <= acc;
            if (acc) begin
                buf_in_addr <= cnt[8:0];
                buf_in_data <= in_data;
                cnt         <= cnt_next;
            end
            case (state)
                ST_HOLD: begin
                    if (pend) begin
                        // pkt_ready follows the final buffer write by one cycle
                        pend      <= 1'b0;
                        pkt_ready <= 1'b1;
                    end else if (done_rise) begin
                        pkt_ready <= 1'b0;
                        pkt_len   <= '0;
                        cnt       <= '0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    if (commit) begin
                        state    <= ST_HOLD;
                        in_ready <= 1'b0;
                        pkt_len  <= cnt_next;
                        pend     <= 1'b1;
                    end else begin
                        in_ready <= 1'b1;
                        if (acc)
                            state <= ST_FILL;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_usb2_ep1_fill.sv
// tb_usb2_ep1_fill: scoreboard bench for usb2_ep1_fill; expected buffer writes are
// queued as bytes are accepted and checked as the DUT writes them.
module tb_usb2_ep1_fill;
    logic       phy_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [8:0] buf_in_addr;
    logic [7:0] buf_in_data;
    logic       buf_in_wren;
    logic       pkt_ready;
    logic [9:0] pkt_len;
    logic       pkt_done = 1'b0;

    int nchk = 0;
    int nfail = 0;
    int wr_cnt = 0;
    logic [16:0] wq[$];
    logic [8:0]  exp_addr = '0;

    usb2_ep1_fill #(.TIMEOUT_CYCLES(16)) dut (
        .phy_clk(phy_clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .buf_in_addr(buf_in_addr),
        .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren), .pkt_ready(pkt_ready),
        .pkt_len(pkt_len), .pkt_done(pkt_done)
    );

    always #5 phy_clk = ~phy_clk;

    always @(negedge phy_clk) begin
        if (reset_n && buf_in_wren) begin
            logic [16:0] e;
            wr_cnt++;
            nchk++;
            if (wq.size() == 0) begin
                nfail++;
                $display("FAIL write_unexpected: got addr %0d data %02h, none expected", buf_in_addr, buf_in_data);
            end else begin
                e = wq.pop_front();
                if ({buf_in_addr, buf_in_data} !== e) begin
                    nfail++;
                    $display("FAIL write: got addr %0d data %02h, expected addr %0d data %02h",
                             buf_in_addr, buf_in_data, e[16:8], e[7:0]);
                end
            end
        end
    end

    task automatic put(input logic [7:0] d, input logic l);
        int k = 0;
        in_data = d;
        in_last = l;
        in_valid = 1'b1;
        @(negedge phy_clk);
        while (!in_ready && k < 50) begin
            k++;
            @(negedge phy_clk);
        end
        nchk++;
        if (!in_ready) begin
            nfail++;
            $display("FAIL put_ready: in_ready %0b, expected 1 within 50 cycles", in_ready);
        end else begin
            wq.push_back({exp_addr, d});
            exp_addr++;
        end
        @(posedge phy_clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic release_pkt();
        pkt_done = 1'b1;
        @(posedge phy_clk);
        #1;
        nchk++;
        if ({pkt_ready, pkt_len, in_ready} !== {1'b0, 10'd0, 1'b1}) begin
            nfail++;
            $display("FAIL release: got ready %0b len %0d in_ready %0b, expected 0 0 1", pkt_ready, pkt_len, in_ready);
        end
        pkt_done = 1'b0;
        exp_addr = '0;
        @(posedge phy_clk);
        #1;
    endtask

    task automatic expect_commit(input logic [9:0] len);
        nchk++;
        if ({in_ready, pkt_ready} !== 2'b00) begin
            nfail++;
            $display("FAIL commit_cycle: got in_ready %0b pkt_ready %0b, expected 0 0", in_ready, pkt_ready);
        end
        @(posedge phy_clk);
        #1;
        nchk++;
        if ({pkt_ready, pkt_len, in_ready} !== {1'b1, len, 1'b0}) begin
            nfail++;
            $display("FAIL commit: got ready %0b len %0d in_ready %0b, expected 1 %0d 0", pkt_ready, pkt_len, in_ready, len);
        end
        @(negedge phy_clk);
        nchk++;
        if (wq.size() != 0) begin
            nfail++;
            $display("FAIL drain: got %0d writes outstanding, expected 0", wq.size());
        end
    endtask

    task automatic test_reset();
        #2;
        nchk++;
        if ({in_ready, pkt_ready, pkt_len, buf_in_wren, buf_in_addr, buf_in_data} !== '0) begin
            nfail++;
            $display("FAIL reset_outputs: got ready %0b pkt %0b len %0d wren %0b addr %0d, expected all 0",
                     in_ready, pkt_ready, pkt_len, buf_in_wren, buf_in_addr);
        end
        @(negedge phy_clk);
        reset_n = 1'b1;
        @(posedge phy_clk);
        #1;
        nchk++;
        if (in_ready !== 1'b1) begin
            nfail++;
            $display("FAIL reset_release: in_ready %0b, expected 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 512; i++) put(8'(i), 1'b0);
        expect_commit(10'd512);
    endtask

    task automatic test_hold();
        int w0 = wr_cnt;
        in_valid = 1'b1;
        in_data = 8'hA5;
        repeat (100) @(posedge phy_clk);
        #1;
        in_valid = 1'b0;
        @(negedge phy_clk);
        nchk++;
        if (wr_cnt != w0 || {pkt_ready, pkt_len, in_ready} !== {1'b1, 10'd512, 1'b0}) begin
            nfail++;
            $display("FAIL hold: got %0d writes ready %0b len %0d in_ready %0b, expected 0 writes 1 512 0",
                     wr_cnt - w0, pkt_ready, pkt_len, in_ready);
        end
        release_pkt();
    endtask

    task automatic test_short_packet();
        for (int i = 0; i < 5; i++) put(8'(8'h40 + i), i == 4);
        expect_commit(10'd5);
        release_pkt();
    endtask

    task automatic test_done_ignored();
        repeat (3) begin
            pkt_done = 1'b1;
            @(posedge phy_clk);
            #1;
            pkt_done = 1'b0;
            @(posedge phy_clk);
            #1;
        end
        nchk++;
        if ({pkt_ready, in_ready} !== 2'b01) begin
            nfail++;
            $display("FAIL done_idle: got ready %0b in_ready %0b, expected 0 1", pkt_ready, in_ready);
        end
        put(8'h77, 1'b0);
        repeat (3) begin
            pkt_done = 1'b1;
            @(posedge phy_clk);
            #1;
            pkt_done = 1'b0;
            @(posedge phy_clk);
            #1;
        end
        nchk++;
        if ({pkt_ready, in_ready} !== 2'b01) begin
            nfail++;
            $display("FAIL done_fill: got ready %0b in_ready %0b, expected 0 1", pkt_ready, in_ready);
        end
        for (int i = 1; i < 512; i++) put(8'($urandom_range(0, 255)), i == 511);
        expect_commit(10'd512);
        repeat (5) @(posedge phy_clk);
        #1;
        nchk++;
        if ({pkt_ready, pkt_len} !== {1'b1, 10'd512}) begin
            nfail++;
            $display("FAIL last512_stable: got ready %0b len %0d, expected 1 512", pkt_ready, pkt_len);
        end
        release_pkt();
        repeat (10) @(posedge phy_clk);
        #1;
        nchk++;
        if ({pkt_ready, in_ready} !== 2'b01) begin
            nfail++;
            $display("FAIL no_zlp: got ready %0b in_ready %0b, expected 0 1", pkt_ready, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 200; i++) put(8'(i * 3), 1'b0);
        @(negedge phy_clk);
        #2;
        reset_n = 1'b0;
        #1;
        nchk++;
        if ({pkt_ready, buf_in_addr, in_ready, buf_in_wren} !== '0) begin
            nfail++;
            $display("FAIL reset_mid: got ready %0b addr %0d in_ready %0b wren %0b, expected all 0",
                     pkt_ready, buf_in_addr, in_ready, buf_in_wren);
        end
        wq.delete();
        exp_addr = '0;
        @(negedge phy_clk);
        reset_n = 1'b1;
        @(posedge phy_clk);
        #1;
        for (int i = 0; i < 4; i++) put(8'(8'hC0 + i), i == 3);
        expect_commit(10'd4);
        release_pkt();
    endtask

    task automatic test_timeout();
        int k = 0;
        for (int i = 0; i < 3; i++) put(8'(8'h10 + i), 1'b0);
`ifdef USB2_EP1_FILL_TIMEOUT_EN
        while (in_ready && k < 40) begin
            k++;
            @(posedge phy_clk);
            #1;
        end
        nchk++;
        if (k != 16) begin
            nfail++;
            $display("FAIL timeout_cycles: got commit after %0d cycles, expected 16", k);
        end
        expect_commit(10'd3);
`else
        repeat (40) @(posedge phy_clk);
        #1;
        nchk++;
        if ({pkt_ready, in_ready} !== 2'b01) begin
            nfail++;
            $display("FAIL no_timeout: got ready %0b in_ready %0b, expected 0 1", pkt_ready, in_ready);
        end
        put(8'h13, 1'b1);
        expect_commit(10'd4);
`endif
        release_pkt();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_hold();
        test_short_packet();
        test_done_ignored();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
